msx_mouse_port_mux: RTL and testbench
=====================================

// Module: msx_mouse_port_mux
// PURPOSE
//  Drives NPORTS MSX general-purpose joystick ports from host joysticks and one PS/2 mouse.
//  Sits between the PS/2 mouse decoder / joystick reader and the emsx_top pJoyA/pJoyB/pStra/pStrb ports.
//  Implements the MSX mouse nibble protocol with a per-port strobe sequencer and saturating delta accumulation.
//  Implements the idle timeout and joystick/mouse mode selection.
// PARAMETERS
//  NPORTS      2       number of MSX joystick ports (1..4)
//  MOUSE_PORT  0       index of the port the mouse is attached to (< NPORTS)
//  TIMEOUT     100000  clk_sys cycles without strobe toggle before the nibble sequence restarts
//  TO_W        18      timeout counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk_sys       in   1         system clock (21.48 MHz)
//  reset         in   1         synchronous, active-high
//  mouse_dx      in   9         signed X delta from PS/2 decoder, valid with mouse_strobe
//  mouse_dy      in   9         signed Y delta, valid with mouse_strobe
//  mouse_btn     in   2         [0]=left [1]=right, active-high
//  mouse_strobe  in   1         1-cycle pulse: new delta/button packet
//  mouse_sel     in   1         static mode select (1=mouse) when MSX_MOUSE_AUTODETECT_EN is undefined
//  joy_i         in   6*NPORTS  host joysticks, active-low, per port {b2,b1,right,left,down,up}
//  str_i         in   NPORTS    MSX strobe (pin 8) per port, from PSG port B
//  joy_o         out  6*NPORTS  to MSX, active-low, same bit order as joy_i
//  mouse_active  out  1         1 = MOUSE_PORT is in mouse mode
// BEHAVIOUR
//  - Reset: joy_o all ones; mouse_active=0; nibble state=0; acc_x=acc_y=0; snap_x=snap_y=0; timeout counter=0.
//  - All outputs registered; joy_o changes exactly 1 clk_sys after the triggering input changes.
//  - Non-mouse ports, and MOUSE_PORT when mouse_active=0: joy_o slice = joy_i slice (1-cycle pass-through).
//  - Accumulation, every cycle regardless of mode:
//    - On mouse_strobe: acc_x <= sat8(acc_x + dx), acc_y <= sat8(acc_y + dy).
//    - sat8 clamps the 10-bit signed sum to [-128,+127].
//  - Strobe edge: the registered str_d[MOUSE_PORT] differs from str_i[MOUSE_PORT]; either polarity counts. Acted on only when mouse_active=1.
//  - Nibble FSM, states S0..S3, advancing on each edge (S3 wraps to S0). Each edge also reloads the timeout counter with TIMEOUT.
//    - Edge in S0: snap <= acc, acc <= 0, joy_o[3:0] <= ~snap_x[7:4], computed from the acc value in the same cycle.
//    - Edge in S1: joy_o[3:0] <= ~snap_x[3:0].
//    - Edge in S2: joy_o[3:0] <= ~snap_y[7:4].
//    - Edge in S3: joy_o[3:0] <= ~snap_y[3:0].
//  - Snapshot and mouse_strobe in the same cycle: snap takes the old acc; acc <= sat8(0 + new delta). No packet is lost.
//  - Timeout: a nonzero counter decrements each cycle. At the transition 1->0, state <= S0 and joy_o is unchanged.
//    - An edge in the same cycle wins: the state advances and the counter reloads.
//  - Mouse mode: joy_o[5:4] <= ~mouse_btn[1:0], updated every cycle.
//  - Mode change to joystick: state <= S0 and the counter is cleared. acc keeps accumulating.
//  - Reset mid-sequence: all state returns to reset values on the next edge; a pending strobe in that cycle is dropped.
// CONFIGURATION
//  MSX_MOUSE_AUTODETECT_EN defined:
//    - mouse_active <= 1 on mouse_strobe.
//    - mouse_active <= 0 when any joy_i bit of MOUSE_PORT is low (0).
//    - If both occur in the same cycle, the joystick wins (mouse_active <= 0).
//    - mouse_sel is ignored.
//  MSX_MOUSE_AUTODETECT_EN undefined: mouse_active <= mouse_sel every cycle (registered); auto-detect logic removed.
// TESTING
//  T1 reset: assert reset 3 cycles -> joy_o=all 1s, mouse_active=0; 1 cycle after release joy_o = joy_i.
//  T2 sequence: dx=+5, dy=-3 strobed, mouse on, 4 str toggles 10 cycles apart -> joy_o[3:0] = ~4'h0, ~4'h5, ~4'hF, ~4'hD.
//  T3 saturation: 3 strobes dx=+100 then S0 edge -> snap_x=0x7F, nibbles ~4'h7, ~4'hF; 2 strobes dx=-100 -> 0x80.
//  T4 timeout: toggle str to S2, idle TIMEOUT cycles -> state S0; next toggle outputs X high nibble.
//  T5 collision: mouse_strobe dx=+2 in the same cycle as an S0 edge with acc=+7 -> nibbles of 0x07; the next sequence reads 0x02.
//  T6 autodetect (macro on): strobe -> mouse_active=1; joy_i up=0 -> mouse_active=0 next cycle, pass-through; (macro off) mouse_sel drives mode.

Source files
------------

// File: rtl/msx_mouse_port_mux_if.sv
// Signal bundle between the PS/2 mouse decoder / joystick reader (master)
// and the MSX joystick port multiplexer (slave).
interface msx_mouse_port_mux_if #(
    parameter int NPORTS = 2
);
    logic signed [8:0]       mouse_dx;
    logic signed [8:0]       mouse_dy;
    logic [1:0]              mouse_btn;
    logic                    mouse_strobe;
    logic                    mouse_sel;
    logic [6*NPORTS-1:0]     joy_i;
    logic [NPORTS-1:0]       str_i;
    logic [6*NPORTS-1:0]     joy_o;
    logic                    mouse_active;

    modport master (
        output mouse_dx, mouse_dy, mouse_btn, mouse_strobe, mouse_sel, joy_i, str_i,
        input  joy_o, mouse_active
    );

    modport slave (
        input  mouse_dx, mouse_dy, mouse_btn, mouse_strobe, mouse_sel, joy_i, str_i,
        output joy_o, mouse_active
    );
endinterface

// File: rtl/msx_mouse_port_mux.sv
// MSX joystick port multiplexer with PS/2 mouse nibble protocol on MOUSE_PORT.
// Define MSX_MOUSE_AUTODETECT_EN to pick mouse/joystick mode from activity instead of mouse_sel.
module msx_mouse_port_mux #(
    parameter int NPORTS     = 2,
    parameter int MOUSE_PORT = 0,
    parameter int TIMEOUT    = 100000,
    parameter int TO_W       = 18
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    msx_mouse_port_mux_if.slave  bus
);
    typedef enum logic [1:0] {S0, S1, S2, S3} nib_state_t;

    nib_state_t      state_reg;
    logic [7:0]      acc_x_reg, acc_y_reg;
    logic [7:0]      snap_x_reg, snap_y_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            str_d_reg;
    logic            mouse_active_reg;
    logic            mouse_active_next;

    logic            str_edge;
    logic            snap_now;
    logic [7:0]      acc_x_base, acc_y_base;
    logic [3:0]      nib_next;

    // Add a 9-bit signed delta to an 8-bit signed accumulator, clamping to [-128,+127].
    function automatic logic [7:0] sat8(input logic [7:0] base, input logic [8:0] delta);
        logic signed [9:0] sum;
        sum = $signed({{2{base[7]}}, base}) + $signed({delta[8], delta});
        if (sum > 10'sd127)
            return 8'h7F;
        else if (sum < -10'sd128)
            return 8'h80;
        return sum[7:0];
    endfunction

    assign str_edge   = mouse_active_reg && (str_d_reg != bus.str_i[MOUSE_PORT]);
    assign snap_now   = str_edge && (state_reg == S0);
    assign acc_x_base = snap_now ? 8'h00 : acc_x_reg;
    assign acc_y_base = snap_now ? 8'h00 : acc_y_reg;

    // The S0 nibble comes straight from the accumulator being snapshotted this cycle.
    always_comb begin
        nib_next = 4'hF;
        case (state_reg)
            S0:      nib_next = ~acc_x_reg[7:4];
            S1:      nib_next = ~snap_x_reg[3:0];
            S2:      nib_next = ~snap_y_reg[7:4];
            default: nib_next = ~snap_y_reg[3:0];
        endcase
    end

`ifdef MSX_MOUSE_AUTODETECT_EN
    logic unused_mouse_sel;
    assign unused_mouse_sel = bus.mouse_sel;

    // Any pressed joystick line on the mouse port overrides a mouse packet in the same cycle.
    always_comb begin
        mouse_active_next = mouse_active_reg;
        if (bus.joy_i[MOUSE_PORT*6 +: 6] != 6'h3F)
            mouse_active_next = 1'b0;
        else if (bus.mouse_strobe)
            mouse_active_next = 1'b1;
    end
`else
    assign mouse_active_next = bus.mouse_sel;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg        <= S0;
            acc_x_reg        <= 8'h00;
            acc_y_reg        <= 8'h00;
            snap_x_reg       <= 8'h00;
            snap_y_reg       <= 8'h00;
            to_cnt_reg       <= '0;
            str_d_reg        <= bus.str_i[MOUSE_PORT];
            mouse_active_reg <= 1'b0;
        end else begin
            str_d_reg        <= bus.str_i[MOUSE_PORT];
            mouse_active_reg <= mouse_active_next;

            if (bus.mouse_strobe) begin
                acc_x_reg <= sat8(acc_x_base, bus.mouse_dx);
                acc_y_reg <= sat8(acc_y_base, bus.mouse_dy);
            end else if (snap_now) begin
                acc_x_reg <= 8'h00;
                acc_y_reg <= 8'h00;
            end

            if (snap_now) begin
                snap_x_reg <= acc_x_reg;
                snap_y_reg <= acc_y_reg;
            end

            if (!mouse_active_reg) begin
                state_reg  <= S0;
                to_cnt_reg <= '0;
            end else if (str_edge) begin
                state_reg  <= nib_state_t'(state_reg + 2'd1);
                to_cnt_reg <= TO_W'(TIMEOUT);
            end else if (to_cnt_reg != '0) begin
                to_cnt_reg <= to_cnt_reg - 1'b1;
                if (to_cnt_reg == TO_W'(1))
                    state_reg <= S0;
            end
        end
    end

    assign bus.mouse_active = mouse_active_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            logic [5:0] joy_q_reg;
            assign bus.joy_o[gi*6 +: 6] = joy_q_reg;

            if (gi == MOUSE_PORT) begin : g_mouse
                always_ff @(posedge clk_sys) begin
                    if (reset) begin
                        joy_q_reg <= 6'h3F;
                    end else if (!mouse_active_reg) begin
                        joy_q_reg <= bus.joy_i[gi*6 +: 6];
                    end else begin
                        joy_q_reg[5:4] <= ~bus.mouse_btn;
                        if (str_edge)
                            joy_q_reg[3:0] <= nib_next;
                    end
                end
            end else begin : g_joy
                always_ff @(posedge clk_sys) begin
                    if (reset)
                        joy_q_reg <= 6'h3F;
                    else
                        joy_q_reg <= bus.joy_i[gi*6 +: 6];
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_msx_mouse_port_mux.sv
// Self-checking bench for msx_mouse_port_mux: directed table/sequences plus a
// randomized run against a packet-level reference model.
module tb_msx_mouse_port_mux;
    localparam int NP  = 2;
    localparam int MP  = 0;
    localparam int TMO = 40;
    localparam int TW  = 8;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    msx_mouse_port_mux_if #(.NPORTS(NP)) mif ();

    msx_mouse_port_mux #(
        .NPORTS(NP), .MOUSE_PORT(MP), .TIMEOUT(TMO), .TO_W(TW)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (mif)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6*NP-1:0] joy;
        logic [6*NP-1:0] exp;
    } vec_t;
    vec_t tbl [4];

    task automatic step();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("ok   %s got=%h", name, got);
        end
    endtask

    task automatic pkt(input int dx, input int dy);
        mif.mouse_dx     = 9'(dx);
        mif.mouse_dy     = 9'(dy);
        mif.mouse_strobe = 1'b1;
        step();
        mif.mouse_strobe = 1'b0;
    endtask

    task automatic tog(input string name, input logic [3:0] exp_nib);
        mif.str_i[MP] = ~mif.str_i[MP];
        step();
        chk(name, 32'(mif.joy_o[MP*6 +: 4]), 32'(exp_nib));
        idle(9);
    endtask

    task automatic activate();
        mif.joy_i = '1;
`ifdef MSX_MOUSE_AUTODETECT_EN
        pkt(0, 0);
`else
        mif.mouse_sel = 1'b1;
        step();
`endif
        chk("activate", 32'(mif.mouse_active), 32'd1);
    endtask

    // ---------------- reference model ----------------
    int m_acc_x, m_acc_y, m_snap_x, m_snap_y, m_idx, m_last, m_cyc;
    bit m_has_edge, m_active, m_edge_seen;
    logic [6*NP-1:0] exp_joy;
    logic            exp_active;
    logic [NP-1:0]   m_str_prev;

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_reset();
        m_acc_x = 0; m_acc_y = 0; m_snap_x = 0; m_snap_y = 0;
        m_idx = 0; m_last = 0; m_cyc = 0; m_has_edge = 0; m_active = 0;
        exp_joy = '1; exp_active = 1'b0; m_str_prev = mif.str_i;
    endtask

    // One clock of behaviour from the inputs currently driven.
    task automatic model_step();
        bit edge_now;
        int word, nib;
        if (!m_active) begin
            m_idx = 0;
            m_has_edge = 0;
        end
        edge_now = m_active && (mif.str_i[MP] != m_str_prev[MP]);
        m_edge_seen = edge_now;
        for (int p = 0; p < NP; p++) begin
            if (p != MP || !m_active) begin
                exp_joy[p*6 +: 6] = mif.joy_i[p*6 +: 6];
            end else begin
                exp_joy[p*6+4 +: 2] = ~mif.mouse_btn;
                if (edge_now) begin
                    if (m_has_edge && (m_cyc - m_last) > TMO) m_idx = 0;
                    if (m_idx == 0) begin
                        m_snap_x = m_acc_x; m_snap_y = m_acc_y;
                        m_acc_x = 0; m_acc_y = 0;
                    end
                    word = ((m_snap_x & 255) << 8) | (m_snap_y & 255);
                    nib  = (word >> (12 - 4*m_idx)) & 15;
                    exp_joy[p*6 +: 4] = ~4'(nib);
                    m_idx = (m_idx + 1) % 4;
                    m_last = m_cyc;
                    m_has_edge = 1;
                end
            end
        end
        if (mif.mouse_strobe) begin
            m_acc_x = clamp8(m_acc_x + int'(mif.mouse_dx));
            m_acc_y = clamp8(m_acc_y + int'(mif.mouse_dy));
        end
`ifdef MSX_MOUSE_AUTODETECT_EN
        if (mif.joy_i[MP*6 +: 6] != 6'h3F) m_active = 0;
        else if (mif.mouse_strobe)        m_active = 1;
`else
        m_active = mif.mouse_sel;
`endif
        exp_active = m_active;
        m_str_prev = mif.str_i;
        m_cyc++;
    endtask

    initial begin
        int cd;
        logic [6*NP-1:0] pre;

        tbl[0] = '{joy: 12'hFFE, exp: 12'hFFE};
        tbl[1] = '{joy: 12'h03F, exp: 12'h03F};
        tbl[2] = '{joy: 12'hAD5, exp: 12'hAD5};
        tbl[3] = '{joy: 12'h5EA, exp: 12'h5EA};

        reset = 1'b1;
        mif.mouse_dx = '0; mif.mouse_dy = '0; mif.mouse_btn = 2'b00;
        mif.mouse_strobe = 1'b0; mif.mouse_sel = 1'b0;
        mif.joy_i = 12'h9A6; mif.str_i = '0;
        @(negedge clk_sys);

        // T1 reset
        idle(3);
        chk("reset_joy_o", 32'(mif.joy_o), 32'hFFF);
        chk("reset_active", 32'(mif.mouse_active), 32'd0);
        reset = 1'b0;
        step();
        chk("release_passthru", 32'(mif.joy_o), 32'h9A6);

        // joystick pass-through table, including one-cycle latency
        for (int i = 0; i < 4; i++) begin
            pre = mif.joy_o;
            mif.joy_i = tbl[i].joy;
            #1;
            chk($sformatf("latency_hold_%0d", i), 32'(mif.joy_o), 32'(pre));
            step();
            chk($sformatf("passthru_%0d", i), 32'(mif.joy_o), 32'(tbl[i].exp));
        end

        // T2 basic nibble sequence
        activate();
        mif.mouse_btn = 2'b01;
        pkt(5, -3);
        tog("t2_n0", 4'hF);
        chk("t2_buttons", 32'(mif.joy_o[MP*6+4 +: 2]), 32'(2'b10));
        tog("t2_n1", 4'hA);
        tog("t2_n2", 4'h0);
        tog("t2_n3", 4'h2);

        // T3 saturation both ways
        pkt(100, 0); pkt(100, 0); pkt(100, 0);
        tog("t3_pos_hi", 4'h8);
        tog("t3_pos_lo", 4'h0);
        tog("t3_pos_y0", 4'hF);
        tog("t3_pos_y1", 4'hF);
        pkt(-100, 0); pkt(-100, 0);
        tog("t3_neg_hi", 4'h7);
        tog("t3_neg_lo", 4'hF);
        tog("t3_neg_y0", 4'hF);
        tog("t3_neg_y1", 4'hF);

        // T4 timeout restarts the sequence at X high nibble
        pkt(8'h35, 0);
        tog("t4_n0", 4'hC);
        tog("t4_n1", 4'hA);
        pkt(8'h61, 0);
        idle(TMO + 5);
        chk("t4_hold_at_timeout", 32'(mif.joy_o[MP*6 +: 4]), 32'hA);
        tog("t4_restart_hi", 4'h9);
        tog("t4_restart_lo", 4'hE);
        tog("t4_y0", 4'hF);
        tog("t4_y1", 4'hF);

        // T5 strobe colliding with the snapshot edge
        pkt(7, 0);
        mif.mouse_dx = 9'd2; mif.mouse_dy = 9'd0; mif.mouse_strobe = 1'b1;
        mif.str_i[MP] = ~mif.str_i[MP];
        step();
        mif.mouse_strobe = 1'b0;
        chk("t5_n0", 32'(mif.joy_o[MP*6 +: 4]), 32'hF);
        idle(9);
        tog("t5_n1", 4'h8);
        tog("t5_n2", 4'hF);
        tog("t5_n3", 4'hF);
        tog("t5_next_hi", 4'hF);
        tog("t5_next_lo", 4'hD);
        tog("t5_next_y0", 4'hF);
        tog("t5_next_y1", 4'hF);

        // reset mid-sequence drops a pending packet
        tog("rst_pre", 4'hF);
        reset = 1'b1;
        mif.mouse_dx = 9'd9; mif.mouse_strobe = 1'b1;
        step();
        mif.mouse_strobe = 1'b0;
        chk("rst_mid_joy", 32'(mif.joy_o), 32'hFFF);
        chk("rst_mid_active", 32'(mif.mouse_active), 32'd0);
        reset = 1'b0;
        mif.mouse_sel = 1'b0;
        step();
        activate();
        tog("rst_post_hi", 4'hF);
        tog("rst_post_lo", 4'hF);

        // T6 mode selection back to joystick
`ifdef MSX_MOUSE_AUTODETECT_EN
        mif.joy_i[MP*6 +: 6] = 6'h3E;
        mif.mouse_strobe = 1'b1;
        step();
        mif.mouse_strobe = 1'b0;
        chk("t6_joy_wins", 32'(mif.mouse_active), 32'd0);
`else
        mif.mouse_sel = 1'b0;
        mif.joy_i[MP*6 +: 6] = 6'h3E;
        step();
        chk("t6_sel_off", 32'(mif.mouse_active), 32'd0);
`endif
        step();
        chk("t6_passthru", 32'(mif.joy_o[MP*6 +: 6]), 32'h3E);

        // randomized run against the model
        reset = 1'b1;
        mif.joy_i = '1;
        idle(2);
        model_reset();
        reset = 1'b0;
        mif.mouse_sel = 1'b1;
        cd = 5;
        for (int c = 0; c < 3000; c++) begin
            total++;
            if (mif.joy_o !== exp_joy) begin
                bad++;
                $display("FAIL rnd_joy cyc=%0d got=%h exp=%h", c, mif.joy_o, exp_joy);
            end
            total++;
            if (mif.mouse_active !== exp_active) begin
                bad++;
                $display("FAIL rnd_active cyc=%0d got=%0d exp=%0d", c, mif.mouse_active, exp_active);
            end
            mif.mouse_strobe = ($urandom_range(3) == 0);
            mif.mouse_dx     = 9'($urandom);
            mif.mouse_dy     = 9'($urandom);
            mif.mouse_btn    = 2'($urandom);
            for (int p = 0; p < NP; p++)
                if (p != MP) mif.joy_i[p*6 +: 6] = 6'($urandom);
            mif.joy_i[MP*6 +: 6] = ($urandom_range(150) == 0) ? 6'($urandom) : 6'h3F;
            if ($urandom_range(300) == 0) mif.mouse_sel = ~mif.mouse_sel;
            for (int p = 0; p < NP; p++)
                if (p != MP) mif.str_i[p] = 1'($urandom);
            cd--;
            if (cd == 0) begin
                mif.str_i[MP] = ~mif.str_i[MP];
                cd = int'($urandom_range(55, 1));
            end
            model_step();
            if (m_edge_seen)
                $display("rnd  edge cyc=%0d exp_nib=%h", c, exp_joy[MP*6 +: 4]);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
